// File: rtl/nn_config_if.sv
// nn_config_if: host word stream in, per-neuron configuration writes out to the network
interface nn_config_if;
  logic        start;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] config_in;
  logic        config_valid;
  logic        config_type;
  logic [1:0]  config_layer_num;
  logic [4:0]  config_neuron_num;
  logic        busy;
  logic        done;
  modport master (
    output start, s_data, s_valid,
    input  s_ready, config_in, config_valid, config_type, config_layer_num, config_neuron_num, busy, done
  );
  modport slave (
    input  start, s_data, s_valid,
    output s_ready, config_in, config_valid, config_type, config_layer_num, config_neuron_num, busy, done
  );
endinterface

// File: rtl/nn_config_loader.sv
// nn_config_loader: streams host words into network weights, then biases (bias pass only with NN_CONFIG_BIAS_EN)
module nn_config_loader #(
  parameter int NUM_LAYERS  = 3,
  parameter int NUM_NEURONS = 30,
  parameter int NUM_WEIGHTS = 784
) (
  input logic       clk,
  input logic       rst,
  nn_config_if.slave bus
);
  localparam int NW = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1;
  localparam int WW = NUM_WEIGHTS > 1 ? $clog2(NUM_WEIGHTS) : 1;
  localparam logic [1:0]    L_MAX = 2'(NUM_LAYERS);
  localparam logic [NW-1:0] N_MAX = NW'(NUM_NEURONS - 1);
  localparam logic [WW-1:0] W_MAX = WW'(NUM_WEIGHTS - 1);
`ifdef NN_CONFIG_BIAS_EN
  typedef enum logic [1:0] {IDLE, WEIGHT, BIAS, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WEIGHT, DONE} state_t;
`endif
  state_t        state;
  logic [1:0]    layer;
  logic [NW-1:0] neuron;
  logic [WW-1:0] widx;
  logic          last_l, last_n, last_w;
  assign last_l = layer == L_MAX;
  assign last_n = neuron == N_MAX;
  assign last_w = widx == W_MAX;
`ifndef NN_CONFIG_BIAS_EN
  assign bus.config_type = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state                 <= IDLE;
      layer                 <= '0;
      neuron                <= '0;
      widx                  <= '0;
      bus.config_valid      <= 1'b0;
      bus.config_in         <= '0;
      bus.config_layer_num  <= '0;
      bus.config_neuron_num <= '0;
      bus.busy              <= 1'b0;
      bus.done              <= 1'b0;
      bus.s_ready           <= 1'b0;
`ifdef NN_CONFIG_BIAS_EN
      bus.config_type       <= 1'b0;
`endif
    end else begin
      bus.config_valid <= 1'b0;
      case (state)
        IDLE, DONE: if (bus.start) begin
          state       <= WEIGHT;
          layer       <= 2'd1;
          neuron      <= '0;
          widx        <= '0;
          bus.done    <= 1'b0;
          bus.busy    <= 1'b1;
          bus.s_ready <= 1'b1;
        end
        WEIGHT: if (bus.s_valid) begin
          bus.config_valid      <= 1'b1;
          bus.config_in         <= {16'd0, bus.s_data[15:0]};
          bus.config_layer_num  <= layer;
          bus.config_neuron_num <= 5'(neuron);
`ifdef NN_CONFIG_BIAS_EN
          bus.config_type       <= 1'b0;
`endif
          widx <= last_w ? '0 : widx + 1'b1;
          if (last_w) begin
            neuron <= last_n ? '0 : neuron + 1'b1;
            if (last_n) layer <= last_l ? 2'd1 : layer + 2'd1;
          end
          if (last_w && last_n && last_l) begin
`ifdef NN_CONFIG_BIAS_EN
            state       <= BIAS;
`else
            state       <= DONE;
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            bus.s_ready <= 1'b0;
`endif
          end
        end
`ifdef NN_CONFIG_BIAS_EN
        BIAS: if (bus.s_valid) begin
          bus.config_valid      <= 1'b1;
          bus.config_in         <= bus.s_data;
          bus.config_type       <= 1'b1;
          bus.config_layer_num  <= layer;
          bus.config_neuron_num <= 5'(neuron);
          neuron <= last_n ? '0 : neuron + 1'b1;
          if (last_n) layer <= last_l ? 2'd1 : layer + 2'd1;
          if (last_n && last_l) begin
            state       <= DONE;
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            bus.s_ready <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_nn_config_loader.sv
// tb_nn_config_loader: scoreboard bench for the loader at 2 layers x 3 neurons x 4 weights
module tb_nn_config_loader;
  localparam int L = 2, N = 3, W = 4, NWT = L * N * W;
`ifdef NN_CONFIG_BIAS_EN
  localparam int NB = L * N;
`else
  localparam int NB = 0;
`endif
  localparam int P = NWT + NB;
  typedef struct {
    logic [31:0] d;
    logic        t;
    logic [1:0]  l;
    logic [4:0]  n;
    logic        last;
  } exp_t;
  logic clk = 0, rst = 1, acc = 0;
  int   total = 0, bad = 0, pulses = 0;
  exp_t q[$];
  exp_t me;
  nn_config_if bus ();
  nn_config_loader #(.NUM_LAYERS(L), .NUM_NEURONS(N), .NUM_WEIGHTS(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask
  function automatic exp_t mk(input int k, input logic [31:0] d);
    exp_t e;
    if (k < NWT) begin
      e.d = {16'h0, d[15:0]};
      e.t = 1'b0;
      e.l = 2'(k / (N * W) + 1);
      e.n = 5'((k % (N * W)) / W);
    end else begin
      e.d = d;
      e.t = 1'b1;
      e.l = 2'((k - NWT) / N + 1);
      e.n = 5'((k - NWT) % N);
    end
    e.last = (k == P - 1);
    return e;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) acc <= 1'b0;
    else acc <= bus.s_valid & bus.s_ready;
  // monitor: every strobe must follow an accepted word and match the scoreboard head
  always @(negedge clk)
    if (!rst && bus.config_valid) begin
      pulses++;
      chk("pulse_after_accept", 32'(acc), 32'd1);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got data %h with no word pending at %0t", bus.config_in, $time);
      end else begin
        me = q.pop_front();
        chk("data", bus.config_in, me.d);
        chk("type", 32'(bus.config_type), 32'(me.t));
        chk("layer", 32'(bus.config_layer_num), 32'(me.l));
        chk("neuron", 32'(bus.config_neuron_num), 32'(me.n));
        if (me.last) begin
          chk("done_with_last", 32'(bus.done), 32'd1);
          chk("busy_with_last", 32'(bus.busy), 32'd0);
        end else chk("done_early", 32'(bus.done), 32'd0);
      end
    end
  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic send(input int k, input logic [31:0] d, input logic st);
    logic r;
    r = 1'b0;
    q.push_back(mk(k, d));
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    bus.start   = st;
    for (int c = 0; c < 50 && !r; c++) begin
      @(negedge clk);
      r = bus.s_ready;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    bus.s_valid = 1'b0;
    if (!r) begin
      total++;
      bad++;
      $display("FAIL send_timeout: word %0d never accepted", k);
    end
  endtask
  // mode 0 back-to-back, 1 DEADBEEF first weight/bias, 2 random gaps, 3 start mid-pass
  task automatic run_pass(input int mode, input logic [31:0] base);
    int p0;
    pulse_start();
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("ready_after_start", 32'(bus.s_ready), 32'd1);
    chk("done_cleared", 32'(bus.done), 32'd0);
    p0 = pulses;
    for (int k = 0; k < P; k++) begin
      if (mode == 2)
        while ($urandom_range(0, 1) == 1) begin
          @(posedge clk);
          #1;
        end
      send(k, (mode == 1 && (k == 0 || k == NWT)) ? 32'hDEADBEEF : base + 32'(k), mode == 3 && k == 10);
    end
    for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("pulse_count", 32'(pulses - p0), 32'(P));
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("done_end", 32'(bus.done), 32'd1);
    chk("busy_end", 32'(bus.busy), 32'd0);
    chk("ready_end", 32'(bus.s_ready), 32'd0);
    @(posedge clk);
    #1;
  endtask
  task automatic reset_test();
    pulse_start();
    for (int k = 0; k < 13; k++) send(k, 32'h100 + 32'(k), 1'b0);
    chk("valid_before_rst", 32'(bus.config_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.config_valid), 32'd0);
    chk("rst_data", bus.config_in, 32'd0);
    chk("rst_type", 32'(bus.config_type), 32'd0);
    chk("rst_layer", 32'(bus.config_layer_num), 32'd0);
    chk("rst_neuron", 32'(bus.config_neuron_num), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.s_ready), 32'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.s_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(bus.s_ready), 32'd0);
    chk("done_after_rst", 32'(bus.done), 32'd0);
    bus.s_valid = 1'b0;
    run_pass(0, 32'h200);
  endtask
  initial begin
    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(bus.config_valid), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_ready", 32'(bus.s_ready), 32'd0);
    chk("reset_layer", 32'(bus.config_layer_num), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready", 32'(bus.s_ready), 32'd0);
    run_pass(0, 32'h0);
    run_pass(1, 32'h1000);
    run_pass(2, 32'h2000);
    run_pass(3, 32'h3000);
    reset_test();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/nn_config_loader.md
NN_CONFIG_LOADER -- requirements
Module: nn_config_loader

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 3, number of layers configured (1..3).
REQ-002 SHALL have parameter NUM_NEURONS, default 30, number of neurons per layer (1..32).
REQ-003 SHALL have parameter NUM_WEIGHTS, default 784, number of weights per neuron (1..1024).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that begins a configuration pass.
REQ-007 SHALL have port s_data, input, 32 bits: host configuration word.
REQ-008 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-009 SHALL have port s_ready, output, 1 bit: the loader accepts a word when s_valid and s_ready are both high.
REQ-010 SHALL have port config_in, output, 32 bits: data to the network.
REQ-011 SHALL have port config_valid, output, 1 bit: one-cycle write strobe.
REQ-012 SHALL have port config_type, output, 1 bit: 0 = weight, 1 = bias.
REQ-013 SHALL have port config_layer_num, output, 2 bits: target layer, counted from 1.
REQ-014 SHALL have port config_neuron_num, output, 5 bits: target neuron, counted from 0.
REQ-015 SHALL have port busy, output, 1 bit: a pass is in progress.
REQ-016 SHALL have port done, output, 1 bit: level signal, high once a pass has completed.

Function
REQ-017 SHALL implement the states IDLE, WEIGHT, BIAS and DONE.
REQ-018 IDLE: start moves to WEIGHT with layer=1, neuron=0, weight index=0; done clears on that same edge.
REQ-019 DONE: start moves to WEIGHT as in REQ-018; otherwise DONE holds.
REQ-020 s_ready SHALL be 1 in WEIGHT and BIAS and 0 in IDLE and DONE; busy SHALL be high in the same states as s_ready.
REQ-021 Each accepted word SHALL produce exactly one config_valid pulse on the next cycle. config_in, config_type, config_layer_num and config_neuron_num SHALL be registered and valid in that same cycle. The latency is 1.
REQ-022 In WEIGHT, config_in SHALL be {16'd0, s_data[15:0]} and config_type SHALL be 0.
REQ-023 In BIAS, config_in SHALL be s_data and config_type SHALL be 1.
REQ-024 In WEIGHT, the loader SHALL traverse in this order: layer 1..NUM_LAYERS (outer), then neuron 0..NUM_NEURONS-1, then weight 0..NUM_WEIGHTS-1 (inner).
- The weight index wraps to 0 when the neuron increments.
- The neuron wraps to 0 when the layer increments.
REQ-025 When the word for the last weight of the last neuron of the last layer is accepted, the loader SHALL go to BIAS with layer=1 and neuron=0.
REQ-026 In BIAS, the loader SHALL traverse layer 1..NUM_LAYERS (outer) and neuron 0..NUM_NEURONS-1 (inner), one word per neuron.
REQ-027 When the last bias word is accepted, the loader SHALL go to DONE. done SHALL go high on the cycle in which the final config_valid is high.
REQ-028 A start received in WEIGHT or BIAS SHALL be ignored, and the counters SHALL be unaffected.
REQ-029 When s_valid is low, the state and counters SHALL hold and config_valid SHALL be 0. Gaps between words of any length are legal.
REQ-030 The counters SHALL be sized to the parameters. Indices SHALL never exceed their maximum values.

Reset
REQ-031 rst high SHALL force, asynchronously:
- the state to IDLE and all counters to 0;
- config_valid=0, config_in=0, config_type=0, config_layer_num=0, config_neuron_num=0;
- busy=0, done=0, s_ready=0.
REQ-032 A reset in the middle of a pass SHALL abandon the pass. No config_valid SHALL occur until a new start is received.

Configuration
REQ-033 With macro NN_CONFIG_BIAS_EN defined, the loader SHALL behave exactly as REQ-025 to REQ-027.
REQ-034 With NN_CONFIG_BIAS_EN undefined:
- the BIAS state SHALL be absent;
- after the last weight is accepted, the loader SHALL go directly to DONE;
- config_type SHALL be constant 0.

Verification (NUM_LAYERS=2, NUM_NEURONS=3, NUM_WEIGHTS=4, NN_CONFIG_BIAS_EN defined unless stated)
REQ-035 Start pulse, then 30 back-to-back words with s_data = index -> 24 weight pulses with config_in = index[15:0] and layer/neuron stepping (1,0)x4, (1,1)x4 … (2,2)x4, then 6 bias pulses (1,0) … (2,2). done rises with the 30th pulse and busy falls on the same cycle.
REQ-036 Word 0xDEADBEEF sent as the first weight and as the first bias -> config_in is 0x0000BEEF with type 0 for the weight, and 0xDEADBEEF with type 1 for the bias.
REQ-037 s_valid toggled pseudo-randomly (50%) -> still exactly 30 pulses in the same order, and no pulse in any cycle following s_valid=0.
REQ-038 Start pulsed after 10 words -> sequence unchanged and total still 30 pulses. Start pulsed in DONE -> new pass begins at (1,0) and done is cleared.
REQ-039 rst asserted after 13 words, then start and 30 words -> outputs go to 0 immediately and the new pass begins at layer 1, neuron 0, weight 0.
REQ-040 With NN_CONFIG_BIAS_EN undefined, 24 words -> done rises with the 24th pulse, s_ready=0 afterward, and config_type is always 0.
